// File: rtl/uart_tx.sv
// UART transmitter: queues words in a small FIFO and serialises them MSB-first as
// start / WIDTH data / STOP_BITS stop frames, each bit lasting DIVISOR clk cycles.
module uart_tx #(
  parameter int unsigned WIDTH      = 8,
  parameter int unsigned DIVISOR    = 100,
  parameter int unsigned FIFO_DEPTH = 4,
  parameter int unsigned STOP_BITS  = 1
) (
  input  logic                          clk,
  input  logic                          i_reset,
  input  logic [WIDTH-1:0]              i_data,
  input  logic                          i_valid,
  output logic                          o_ready,
  output logic                          o_tx,
  output logic                          o_busy,
  output logic [$clog2(FIFO_DEPTH):0]   o_fifo_count
);

  localparam int unsigned PW = $clog2(FIFO_DEPTH);
  localparam int unsigned DW = $clog2(DIVISOR * STOP_BITS);
  localparam int unsigned BW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  localparam logic [DW-1:0] BitLast   = DW'(DIVISOR - 1);
  localparam logic [DW-1:0] StopLast  = DW'(DIVISOR * STOP_BITS - 1);
  localparam logic [BW-1:0] IdxLast   = BW'(WIDTH - 1);
  localparam logic [PW:0]   CountFull = (PW + 1)'(FIFO_DEPTH);

  localparam logic [1:0] StIdle  = 2'd0;
  localparam logic [1:0] StStart = 2'd1;
  localparam logic [1:0] StData  = 2'd2;
  localparam logic [1:0] StStop  = 2'd3;

  // FIFO storage and pointers
  logic [WIDTH-1:0] mem [FIFO_DEPTH];
  logic [PW-1:0]    wr_ptr_q;
  logic [PW-1:0]    rd_ptr_q;
  logic [PW:0]      count_q;
  logic             push;
  logic             pop;
  logic             fifo_nonempty;

  // Serialiser state
  logic [1:0]       state_q, state_d;
  logic [DW-1:0]    div_q, div_d;
  logic [BW-1:0]    bit_idx_q, bit_idx_d;
  logic [WIDTH-1:0] shift_q, shift_d;
  logic             tx_line;

  assign o_ready       = (count_q < CountFull);
  assign push          = i_valid && o_ready;
  assign fifo_nonempty = (count_q != '0);
  assign o_fifo_count  = count_q;
  assign o_busy        = (state_q != StIdle) || fifo_nonempty;

  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr_q] <= i_data;
    end
  end

  always_ff @(posedge clk) begin
    if (i_reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      case ({push, pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

  always_comb begin
    state_d   = state_q;
    div_d     = div_q;
    bit_idx_d = bit_idx_q;
    shift_d   = shift_q;
    pop       = 1'b0;
    case (state_q)
      StIdle: begin
        if (fifo_nonempty) begin
          pop     = 1'b1;
          shift_d = mem[rd_ptr_q];
          div_d   = '0;
          state_d = StStart;
        end
      end
      StStart: begin
        if (div_q == BitLast) begin
          div_d     = '0;
          bit_idx_d = IdxLast;
          state_d   = StData;
        end else begin
          div_d = div_q + 1'b1;
        end
      end
      StData: begin
        if (div_q == BitLast) begin
          div_d = '0;
          if (bit_idx_q == '0) begin
            state_d = StStop;
          end else begin
            bit_idx_d = bit_idx_q - 1'b1;
          end
        end else begin
          div_d = div_q + 1'b1;
        end
      end
      StStop: begin
        if (div_q == StopLast) begin
          div_d = '0;
          // Chain straight into the next frame when more words are waiting
          if (fifo_nonempty) begin
            pop     = 1'b1;
            shift_d = mem[rd_ptr_q];
            state_d = StStart;
          end else begin
            state_d = StIdle;
          end
        end else begin
          div_d = div_q + 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    tx_line = 1'b1;
    case (state_q)
      StStart: tx_line = 1'b0;
      StData:  tx_line = shift_q[bit_idx_q];
      default: tx_line = 1'b1;
    endcase
  end

  always_ff @(posedge clk) begin
    if (i_reset) begin
      state_q   <= StIdle;
      div_q     <= '0;
      bit_idx_q <= '0;
      shift_q   <= '0;
      o_tx      <= 1'b1;
    end else begin
      state_q   <= state_d;
      div_q     <= div_d;
      bit_idx_q <= bit_idx_d;
      shift_q   <= shift_d;
      o_tx      <= tx_line;
    end
  end

endmodule

// File: tb/tb_uart_tx.sv
// Directed bench for uart_tx: line timing, FIFO flow control, reset abort and
// two stop bits, with a bench-side serial receiver decoding the line.
module tb_uart_tx;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] i_data, d2;
  logic       i_valid, v2;
  logic       o_ready, o_tx, o_busy;
  logic       rdy2, tx2, busy2;
  logic [2:0] o_fifo_count, cnt2;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  uart_tx #(.WIDTH(8), .DIVISOR(4), .FIFO_DEPTH(4), .STOP_BITS(1)) dut (
    .clk(clk), .i_reset(rst), .i_data(i_data), .i_valid(i_valid), .o_ready(o_ready),
    .o_tx(o_tx), .o_busy(o_busy), .o_fifo_count(o_fifo_count)
  );

  uart_tx #(.WIDTH(8), .DIVISOR(4), .FIFO_DEPTH(4), .STOP_BITS(2)) dut2 (
    .clk(clk), .i_reset(rst), .i_data(d2), .i_valid(v2), .o_ready(rdy2),
    .o_tx(tx2), .o_busy(busy2), .o_fifo_count(cnt2)
  );

  // Receiver for dut: sample mid-bit (4 cycles/bit), one stop bit
  int         cyc = 0;
  logic       rx_act = 1'b0;
  int         rx_cnt = 0;
  int         rx_t0 = 0;
  int         rx_err = 0;
  logic [7:0] rx_sh = 8'h00;
  logic [7:0] rx_q[$];
  int         st_q[$];

  always @(negedge clk) begin
    cyc <= cyc + 1;
    if (rst) begin
      rx_act <= 1'b0;
    end else if (!rx_act) begin
      if (o_tx === 1'b0) begin
        rx_act <= 1'b1;
        rx_cnt <= 1;
        rx_t0  <= cyc;
      end
    end else begin
      rx_cnt <= rx_cnt + 1;
      if (rx_cnt == 2 && o_tx !== 1'b0) rx_err <= rx_err + 1;
      if (rx_cnt >= 6 && rx_cnt <= 34 && (rx_cnt % 4) == 2) rx_sh <= {rx_sh[6:0], o_tx};
      if (rx_cnt == 38) begin
        rx_act <= 1'b0;
        if (o_tx !== 1'b1) rx_err <= rx_err + 1;
        rx_q.push_back(rx_sh);
        st_q.push_back(rx_t0);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic frame_bit(input logic [7:0] d, input int k);
    if (k == 0) return 1'b0;
    else if (k <= 8) return d[8-k];
    else return 1'b1;
  endfunction

  task automatic wait_idle(input int lim, input string tag);
    int n = 0;
    while ((o_busy || rx_act) && n < lim) begin
      tick();
      n++;
    end
    chk({tag, "_timeout"}, 32'(n < lim), 32'd1);
    repeat (2) tick();
  endtask

  task automatic push_word(input logic [7:0] w, input string tag);
    i_data  = w;
    i_valid = 1'b1;
    chk({tag, "_ready"}, 32'(o_ready), 32'd1);
    tick();
    i_valid = 1'b0;
  endtask

  initial begin #200000; $display("FAIL watchdog: simulation time limit"); $fatal(1); end

  initial begin
    logic [7:0] w1 [6];
    int exp_cnt [6];
    int exp_rdy [6];
    int guard;
    logic saw_low;

    rst = 1'b1; i_valid = 1'b0; i_data = 8'h00; v2 = 1'b0; d2 = 8'h00;
    repeat (3) tick();
    chk("rst_tx", 32'(o_tx), 32'd1);
    chk("rst_ready", 32'(o_ready), 32'd1);
    chk("rst_busy", 32'(o_busy), 32'd0);
    chk("rst_count", 32'(o_fifo_count), 32'd0);
    chk("rst_tx2", 32'(tx2), 32'd1);
    rst = 1'b0;
    repeat (2) tick();

    // Single word 0xA5: line 0,1,0,1,0,0,1,0,1,1 at 4 cycles per bit
    i_data = 8'hA5; i_valid = 1'b1;
    tick();
    i_valid = 1'b0;
    chk("a5_count_after_push", 32'(o_fifo_count), 32'd1);
    chk("a5_busy_after_push", 32'(o_busy), 32'd1);
    chk("a5_tx_idle_n1", 32'(o_tx), 32'd1);
    tick();
    chk("a5_count_after_pop", 32'(o_fifo_count), 32'd0);
    chk("a5_tx_idle_n2", 32'(o_tx), 32'd1);
    for (int j = 0; j < 40; j++) begin
      tick();
      chk($sformatf("a5_tx_%0d", j), 32'(o_tx), 32'(frame_bit(8'hA5, j / 4)));
      chk($sformatf("a5_busy_%0d", j), 32'(o_busy), (j < 39) ? 32'd1 : 32'd0);
    end
    chk("a5_rx_n", 32'(rx_q.size()), 32'd1);
    chk("a5_rx_word", 32'(rx_q[0]), 32'hA5);
    repeat (3) tick();

    // Six words held on i_valid against a 4-deep FIFO
    rx_q.delete(); st_q.delete();
    w1 = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06};
    exp_cnt = '{1, 1, 2, 3, 4, 4};
    exp_rdy = '{1, 1, 1, 1, 0, 0};
    for (int w = 0; w < 6; w++) begin
      i_data = w1[w]; i_valid = 1'b1;
      guard = 0;
      while (!o_ready && guard < 200) begin
        chk("burst_full_count", 32'(o_fifo_count), 32'd4);
        tick();
        guard++;
      end
      tick();
      chk($sformatf("burst_count_%0d", w), 32'(o_fifo_count), 32'(exp_cnt[w]));
      chk($sformatf("burst_ready_%0d", w), 32'(o_ready), 32'(exp_rdy[w]));
      if (w == 5) chk("burst_waited", 32'(guard > 0 && guard < 200), 32'd1);
    end
    i_valid = 1'b0;
    wait_idle(400, "burst");
    chk("burst_rx_n", 32'(rx_q.size()), 32'd6);
    for (int w = 0; w < 6; w++) chk($sformatf("burst_word_%0d", w), 32'(rx_q[w]), 32'(w + 1));
    for (int w = 1; w < 6; w++)
      chk($sformatf("burst_gap_%0d", w), 32'(st_q[w] - st_q[w-1]), 32'd40);
    chk("burst_total", 32'(st_q[5] - st_q[0]), 32'd200);

    // i_valid toggled while full: 0xEE must never be taken
    rx_q.delete(); st_q.delete();
    push_word(8'h11, "full_p0");
    push_word(8'h22, "full_p1");
    push_word(8'h33, "full_p2");
    push_word(8'h44, "full_p3");
    push_word(8'h55, "full_p4");
    chk("full_count", 32'(o_fifo_count), 32'd4);
    chk("full_ready", 32'(o_ready), 32'd0);
    i_data = 8'hEE;
    for (int j = 0; j < 6; j++) begin
      i_valid = ~i_valid;
      tick();
      chk($sformatf("full_hold_%0d", j), 32'(o_fifo_count), 32'd4);
    end
    i_valid = 1'b0;
    wait_idle(600, "full");
    chk("full_rx_n", 32'(rx_q.size()), 32'd5);
    for (int w = 0; w < 5; w++)
      chk($sformatf("full_word_%0d", w), 32'(rx_q[w]), 32'((w + 1) * 8'h11));

    // Loopback through the bench receiver
    rx_q.delete(); st_q.delete();
    push_word(8'h00, "lb_p0");
    push_word(8'hFF, "lb_p1");
    push_word(8'h55, "lb_p2");
    push_word(8'h80, "lb_p3");
    wait_idle(400, "lb");
    chk("lb_rx_n", 32'(rx_q.size()), 32'd4);
    chk("lb_w0", 32'(rx_q[0]), 32'h00);
    chk("lb_w1", 32'(rx_q[1]), 32'hFF);
    chk("lb_w2", 32'(rx_q[2]), 32'h55);
    chk("lb_w3", 32'(rx_q[3]), 32'h80);
    chk("lb_frame_err", 32'(rx_err), 32'd0);

    // Reset during DATA with two words queued
    rx_q.delete(); st_q.delete();
    push_word(8'h3C, "rst_p0");
    push_word(8'h5A, "rst_p1");
    push_word(8'h96, "rst_p2");
    repeat (20) tick();
    chk("mid_count", 32'(o_fifo_count), 32'd2);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("abort_tx", 32'(o_tx), 32'd1);
    chk("abort_count", 32'(o_fifo_count), 32'd0);
    chk("abort_ready", 32'(o_ready), 32'd1);
    chk("abort_busy", 32'(o_busy), 32'd0);
    saw_low = 1'b0;
    repeat (100) begin
      tick();
      if (o_tx !== 1'b1) saw_low = 1'b1;
    end
    chk("abort_line_quiet", 32'(saw_low), 32'd0);
    chk("abort_rx_n", 32'(rx_q.size()), 32'd0);

    // Two stop bits: 44-cycle frames back to back
    d2 = 8'hC3; v2 = 1'b1;
    tick();
    chk("s2_count_p0", 32'(cnt2), 32'd1);
    d2 = 8'h3C;
    tick();
    v2 = 1'b0;
    chk("s2_count_p1", 32'(cnt2), 32'd1);
    chk("s2_tx_pre", 32'(tx2), 32'd1);
    for (int j = 0; j < 88; j++) begin
      tick();
      chk($sformatf("s2_tx_%0d", j), 32'(tx2),
          32'(frame_bit((j < 44) ? 8'hC3 : 8'h3C, (j % 44) / 4)));
    end
    chk("s2_busy_end", 32'(busy2), 32'd0);
    tick();
    chk("s2_tx_end", 32'(tx2), 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
